// File: rtl/timed_kick_ctrl_if.sv
// Command handshake bundle for timed_kick_ctrl: a command word qualified by
// cmd_valid, with cmd_ready reporting when the controller will take it.
interface timed_kick_ctrl_if #(
   parameter int CMD_W = 7
) ();
   logic [CMD_W-1:0] cmd;
   logic             cmd_valid;
   logic             cmd_ready;

   modport master (
      output cmd,
      output cmd_valid,
      input  cmd_ready
   );

   modport slave (
      input  cmd,
      input  cmd_valid,
      output cmd_ready
   );
endinterface

// File: rtl/timed_kick_ctrl.sv
// Kicker/chipper solenoid sequencer: charge, wait for a command, fire a timed
// pulse on one channel, then hold a lockout before recharging.
module timed_kick_ctrl #(
   parameter int CMD_W           = 7,
   parameter int UNIT_CYCLES     = 100,
   parameter int MAX_STRENGTH    = (1 << (CMD_W - 1)) - 1,
   parameter int COOLDOWN_CYCLES = 1000,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   timed_kick_ctrl_if.slave cmd_bus,
   input  logic             abort,
   input  logic             charge_done,
   output logic             charge_en,
   output logic             kick_out,
   output logic             chip_out,
   output logic             busy,
   output logic [CNT_W-1:0] fire_count
);

   localparam int S_W       = CMD_W - 1;
   localparam int PULSE_MAX = MAX_STRENGTH * UNIT_CYCLES;
   localparam int PULSE_W   = (PULSE_MAX > 1) ? $clog2(PULSE_MAX + 1) : 1;
   localparam int COOL_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

   localparam logic [S_W-1:0]     MAX_S     = S_W'(MAX_STRENGTH);
   localparam logic [PULSE_W-1:0] UNIT_LEN  = PULSE_W'(UNIT_CYCLES);
   localparam logic [COOL_W-1:0]  COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_CHARGE   = 2'd0,
      ST_READY    = 2'd1,
      ST_FIRE     = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [PULSE_W-1:0] pulse_cnt_r;
   logic [PULSE_W-1:0] pulse_cnt_s;
   logic [COOL_W-1:0]  cool_cnt_r;
   logic [COOL_W-1:0]  cool_cnt_s;
   logic               chan_r;
   logic               chan_s;
   logic [CNT_W-1:0]   fire_count_r;
   logic [CNT_W-1:0]   fire_count_s;

   logic               charge_en_r;
   logic               charge_en_s;
   logic               cmd_ready_r;
   logic               cmd_ready_s;
   logic               kick_r;
   logic               kick_s;
   logic               chip_r;
   logic               chip_s;
   logic               busy_r;
   logic               busy_s;

   logic [S_W-1:0]     strength_raw_s;
   logic [S_W-1:0]     strength_s;
   logic [PULSE_W-1:0] pulse_len_s;
   logic               accept_s;

   assign strength_raw_s = cmd_bus.cmd[S_W-1:0];
   assign strength_s     = (strength_raw_s > MAX_S) ? MAX_S : strength_raw_s;
   assign pulse_len_s    = PULSE_W'(strength_s) * UNIT_LEN;
   assign accept_s       = (state_r == ST_READY) && cmd_bus.cmd_valid && charge_done && !abort;

   // Next-state, counter and output decode; outputs follow the next state so they register cleanly.
   always_comb begin
      state_s      = state_r;
      pulse_cnt_s  = pulse_cnt_r;
      cool_cnt_s   = cool_cnt_r;
      chan_s       = chan_r;
      fire_count_s = fire_count_r;

      case (state_r)
         ST_CHARGE: begin
            if (charge_done) begin
               state_s = ST_READY;
            end else begin
               state_s = ST_CHARGE;
            end
         end
         ST_READY: begin
            // A zero-strength command is consumed but leaves the block armed.
            if (accept_s && (strength_s != {S_W{1'b0}})) begin
               state_s      = ST_FIRE;
               chan_s       = cmd_bus.cmd[CMD_W-1];
               pulse_cnt_s  = pulse_len_s - PULSE_W'(1);
               fire_count_s = fire_count_r + CNT_W'(1);
            end else if (!charge_done) begin
               state_s = ST_CHARGE;
            end else begin
               state_s = ST_READY;
            end
         end
         ST_FIRE: begin
            if (abort || (pulse_cnt_r == {PULSE_W{1'b0}})) begin
               state_s    = ST_COOLDOWN;
               cool_cnt_s = COOL_LOAD;
            end else begin
               pulse_cnt_s = pulse_cnt_r - PULSE_W'(1);
            end
         end
         ST_COOLDOWN: begin
            if (cool_cnt_r == {COOL_W{1'b0}}) begin
               state_s = ST_CHARGE;
            end else begin
               cool_cnt_s = cool_cnt_r - COOL_W'(1);
            end
         end
         default: begin
            state_s = ST_CHARGE;
         end
      endcase

      charge_en_s = (state_s == ST_CHARGE) || (state_s == ST_READY);
      cmd_ready_s = (state_s == ST_READY);
      kick_s      = (state_s == ST_FIRE) && !chan_s;
      chip_s      = (state_s == ST_FIRE) && chan_s;
      busy_s      = (state_s == ST_FIRE) || (state_s == ST_COOLDOWN);
   end

   // State, counters and registered outputs; reset lands directly in CHARGE with drives off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_CHARGE;
         pulse_cnt_r  <= {PULSE_W{1'b0}};
         cool_cnt_r   <= {COOL_W{1'b0}};
         chan_r       <= 1'b0;
         fire_count_r <= {CNT_W{1'b0}};
         charge_en_r  <= 1'b1;
         cmd_ready_r  <= 1'b0;
         kick_r       <= 1'b0;
         chip_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         pulse_cnt_r  <= pulse_cnt_s;
         cool_cnt_r   <= cool_cnt_s;
         chan_r       <= chan_s;
         fire_count_r <= fire_count_s;
         charge_en_r  <= charge_en_s;
         cmd_ready_r  <= cmd_ready_s;
         kick_r       <= kick_s;
         chip_r       <= chip_s;
         busy_r       <= busy_s;
      end
   end

   assign charge_en         = charge_en_r;
   assign cmd_bus.cmd_ready = cmd_ready_r;
   assign kick_out          = kick_r;
   assign chip_out          = chip_r;
   assign busy              = busy_r;
   assign fire_count        = fire_count_r;

endmodule

// File: tb/tb_timed_kick_ctrl.sv
// Directed bench for timed_kick_ctrl with UNIT_CYCLES=4, COOLDOWN_CYCLES=8:
// a single-cycle vector table for the handshake, then multi-cycle fire sequences.
module tb_timed_kick_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       abort;
   logic       charge_done;
   logic       charge_en;
   logic       kick_out;
   logic       chip_out;
   logic       busy;
   logic [7:0] fire_count;

   int vec_cnt     = 0;
   int miscompares = 0;

   timed_kick_ctrl_if #(.CMD_W(7)) bus ();

   timed_kick_ctrl #(
      .CMD_W          (7),
      .UNIT_CYCLES    (4),
      .COOLDOWN_CYCLES(8),
      .CNT_W          (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_bus    (bus),
      .abort      (abort),
      .charge_done(charge_done),
      .charge_en  (charge_en),
      .kick_out   (kick_out),
      .chip_out   (chip_out),
      .busy       (busy),
      .fire_count (fire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       cd;
      logic       vld;
      logic [6:0] cmd;
      logic       ab;
      logic       ce_care;
      logic       ce;
      logic       rdy;
      logic       kick;
      logic       chip;
      logic       busy;
      logic [7:0] fc;
   } vec_t;

   vec_t vecs[11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic ce_care, input logic e_ce, input logic e_rdy,
                      input logic e_kick, input logic e_chip, input logic e_busy, input logic [7:0] e_fc);
      vec_cnt++;
      if ((ce_care && (charge_en !== e_ce)) || (bus.cmd_ready !== e_rdy) || (kick_out !== e_kick) ||
          (chip_out !== e_chip) || (busy !== e_busy) || (fire_count !== e_fc)) begin
         miscompares++;
         $display("FAIL %s @%0t: got ce=%b rdy=%b kick=%b chip=%b busy=%b fc=%0d, want ce=%b rdy=%b kick=%b chip=%b busy=%b fc=%0d",
                  name, $time, charge_en, bus.cmd_ready, kick_out, chip_out, busy, fire_count,
                  e_ce, e_rdy, e_kick, e_chip, e_busy, e_fc);
      end
   endtask

   // Starts in READY, fires, checks every pulse and cooldown cycle, and returns in READY.
   task automatic fire_seq(input string name, input logic [6:0] c, input int plen, input logic is_chip,
                           input int abort_at, input logic [7:0] fc_exp);
      int active;
      active = (abort_at > 0) ? abort_at : plen;
      bus.cmd = c; bus.cmd_valid = 1'b1; charge_done = 1'b1; abort = 1'b0;
      step();
      for (int i = 1; i <= active; i++) begin
         chk({name, "_pulse"}, 1'b1, 1'b0, 1'b0, !is_chip, is_chip, 1'b1, fc_exp);
         bus.cmd = 7'h7F; bus.cmd_valid = 1'b1; charge_done = i[0]; abort = (i == abort_at);
         step();
      end
      for (int j = 1; j <= 8; j++) begin
         chk({name, "_cool"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fc_exp);
         bus.cmd = 7'h45; bus.cmd_valid = 1'b1; charge_done = j[0]; abort = (j == 1);
         step();
      end
      chk({name, "_charge"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fc_exp);
      bus.cmd = 7'h7F; bus.cmd_valid = 1'b1; charge_done = 1'b1; abort = 1'b0;
      step();
      chk({name, "_ready"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fc_exp);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] fc_k;
      rst = 1'b1; abort = 1'b0; charge_done = 1'b0; bus.cmd = 7'h00; bus.cmd_valid = 1'b0;

      //              rst   cd    vld   cmd    ab    care  ce    rdy   kick  chip  busy  fc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 7'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 7'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 7'h05, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 7'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 7'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

      for (int v = 0; v < 11; v++) begin
         rst = vecs[v].rst; charge_done = vecs[v].cd; bus.cmd_valid = vecs[v].vld;
         bus.cmd = vecs[v].cmd; abort = vecs[v].ab;
         step();
         chk($sformatf("vec%0d", v), vecs[v].ce_care, vecs[v].ce, vecs[v].rdy,
             vecs[v].kick, vecs[v].chip, vecs[v].busy, vecs[v].fc);
      end

      fire_seq("kick5", 7'h05, 20, 1'b0, 0, 8'd1);
      fire_seq("chip3", 7'h43, 12, 1'b1, 0, 8'd2);
      fire_seq("abort63", 7'h3F, 252, 1'b0, 5, 8'd3);

      // Reset in the middle of a pulse drops the drive immediately and skips cooldown.
      bus.cmd = 7'h05; bus.cmd_valid = 1'b1; charge_done = 1'b1; abort = 1'b0;
      step();
      chk("rstfire_pulse1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
      bus.cmd_valid = 1'b0;
      step();
      chk("rstfire_pulse2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
      rst = 1'b1;
      step();
      chk("rstfire_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      step();
      chk("rstfire_ready", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      for (int k = 1; k <= 256; k++) begin
         fc_k = 8'(k);
         fire_seq("wrap", 7'h01, 4, 1'b0, 0, fc_k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/timed_kick_ctrl.md
TIMED_KICK_CTRL -- requirements
Module: timed_kick_ctrl

Interface
REQ-001 Parameter CMD_W, 7, command width: bit CMD_W-1 = channel select (0 kick, 1 chip), bits CMD_W-2:0 = strength.
REQ-002 Parameter UNIT_CYCLES, 100, clk cycles per strength step.
REQ-003 Parameter MAX_STRENGTH, 2^(CMD_W-1)-1, strength clamp value.
REQ-004 Parameter COOLDOWN_CYCLES, 1000, post-fire lockout length in clk cycles.
REQ-005 Parameter CNT_W, 8, fire_count width.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 cmd  input  CMD_W  kick command (channel + strength).
REQ-009 cmd_valid  input  1  cmd is valid this cycle.
REQ-010 cmd_ready  output  1  block accepts cmd this cycle.
REQ-011 abort  input  1  terminate an active pulse.
REQ-012 charge_done  input  1  capacitor charged, level.
REQ-013 charge_en  output  1  enable charger.
REQ-014 kick_out  output  1  kick solenoid drive.
REQ-015 chip_out  output  1  chip solenoid drive.
REQ-016 busy  output  1  high in FIRE or COOLDOWN.
REQ-017 fire_count  output  CNT_W  number of pulses started.

Function
REQ-018 FSM states SHALL be CHARGE, READY, FIRE, COOLDOWN; all outputs registered.
REQ-019 CHARGE: charge_en=1, cmd_ready=0; charge_done=1 -> READY next cycle.
REQ-020 READY: charge_en=1, cmd_ready=1; charge_done=0 -> CHARGE next cycle, cmd_ready=0 from that cycle.
REQ-021 Acceptance = READY && cmd_valid && charge_done && !abort; channel and strength latched that cycle.
REQ-022 Accepted strength 0: command discarded, remain READY, no output, fire_count unchanged.
REQ-023 Accepted strength > MAX_STRENGTH: clamped to MAX_STRENGTH.
REQ-024 Accepted strength S>0: FIRE next cycle; selected output high for exactly S*UNIT_CYCLES consecutive cycles starting the cycle after acceptance.
REQ-025 Pulse counter SHALL be wide enough for MAX_STRENGTH*UNIT_CYCLES without overflow.
REQ-026 FIRE: charge_en=0, cmd_ready=0; on final pulse cycle -> COOLDOWN, output low next cycle.
REQ-027 abort=1 in FIRE: output low next cycle, -> COOLDOWN; abort in other states ignored except blocking acceptance (REQ-021).
REQ-028 COOLDOWN: all drive outputs and charge_en 0 for exactly COOLDOWN_CYCLES cycles, then -> CHARGE.
REQ-029 kick_out and chip_out SHALL never both be 1.
REQ-030 fire_count increments by 1 on each FIRE entry, wraps from 2^CNT_W-1 to 0.
REQ-031 cmd_valid outside READY ignored, not queued.
REQ-032 charge_done changes during FIRE/COOLDOWN have no effect.

Reset
REQ-033 rst=1 at a clock edge: state CHARGE, kick_out=0, chip_out=0, busy=0, cmd_ready=0, fire_count=0, internal counters 0; charge_en=1 on first cycle after rst deasserts.
REQ-034 rst mid-FIRE: drive output low at that edge; no cooldown entered.

Verification (UNIT_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-035 rst, charge_done=1, cmd=0x05 valid in READY -> kick_out high 20 cycles, busy for 28, fire_count=1, then CHARGE.
REQ-036 cmd=0x43 (chip, S=3) -> chip_out high 12 cycles, kick_out stays 0.
REQ-037 cmd=0x00 or 0x40 -> no output, remains READY, fire_count=0.
REQ-038 cmd=0x3F, abort on pulse cycle 5 -> kick_out low next cycle, 8 cooldown cycles, CHARGE.
REQ-039 cmd_valid during FIRE/COOLDOWN/CHARGE -> ignored; rst asserted mid-FIRE -> outputs 0, fire_count=0.
REQ-040 256 accepted fires -> fire_count wraps to 0.
